instruction_fetch_stage: RTL and testbench

- IF stage of the MIPS pipeline. Owns the PC, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID register.
- The IF/ID register's Instr[31:26] is the OPCode input of the control unit downstream.
- Handles stall from hazard logic, branch redirect/flush from EX, and variable-latency instruction memory.

---
 rtl/mips_pkg.sv | 17 +
 rtl/if_id_register.sv | 32 +++
 rtl/instruction_fetch_stage.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, reset/bubble constants
// and the opcode field position used by both IF and the control unit.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds the fetched instruction, its PC+4 and a valid
// flag. Flush inserts a bubble and wins over load; neither means hold.
module if_id_register #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_d,
    input  logic [31:0] pcplus4_d,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr   <= NOP_INSTR;
            pcplus4 <= 32'h0;
            valid   <= 1'b0;
        end else if (flush) begin
            instr   <= NOP_INSTR;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= instr_d;
            pcplus4 <= pcplus4_d;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: owns the PC, fetches over a req/ack instruction-memory
// handshake, and feeds the IF/ID register with stall and branch-redirect handling.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Stall,
    input  logic         BranchTaken,
    input  logic [31:0]  BranchTarget,
    output logic         ImemReq,
    output logic [31:0]  ImemAddr,
    input  logic [31:0]  ImemRdata,
    input  logic         ImemAck,
    output logic [31:0]  Instr,
    output logic [5:0]   OPCode,
    output logic [31:0]  PCPlus4,
    output logic         InstrValid,
    output fetch_state_e state_dbg
);

    // Handshake: ImemReq/ImemAddr are held constant from the cycle ImemReq
    // rises until the rising edge where ImemAck=1 (a one-cycle pulse, possibly
    // in the same cycle ImemReq rises); a request is never withdrawn early.
    fetch_state_e state, state_next;
    logic [31:0]  pc, pc_next, pc_inc;
    logic [31:0]  skid, skid_next;
    logic [31:0]  redirect_pc, redirect_next;
    logic [31:0]  target;
    logic [31:0]  ifid_instr_d, ifid_pcplus4_d;
    logic         ifid_load, ifid_flush;
    logic         unused_target_lsbs;

    assign target             = {BranchTarget[31:2], 2'b00};
    assign unused_target_lsbs = ^BranchTarget[1:0];
    assign pc_inc             = pc + 32'd4;

    assign ImemReq   = !reset && (state != HOLD);
    assign ImemAddr  = pc;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            skid        <= 32'h0;
            redirect_pc <= 32'h0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            skid        <= skid_next;
            redirect_pc <= redirect_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        skid_next      = skid;
        redirect_next  = redirect_pc;
        ifid_load      = 1'b0;
        ifid_flush     = 1'b0;
        ifid_instr_d   = ImemRdata;
        ifid_pcplus4_d = pc_inc;
        unique case (state)
            FETCH: begin
                if (ImemAck) begin
                    if (BranchTaken) begin
                        pc_next    = target;
                        ifid_flush = 1'b1;
                    end else if (!Stall) begin
                        pc_next   = pc_inc;
                        ifid_load = 1'b1;
                    end else begin
                        skid_next  = ImemRdata;
                        pc_next    = pc_inc;
                        state_next = HOLD;
                    end
                end else if (BranchTaken) begin
                    redirect_next = target;
                    ifid_flush    = 1'b1;
                    state_next    = DISCARD;
                end else if (!Stall) begin
                    ifid_flush = 1'b1;
                end
            end
            DISCARD: begin
                // The in-flight word must still be accepted before redirecting.
                ifid_flush = 1'b1;
                if (BranchTaken) redirect_next = target;
                if (ImemAck) begin
                    pc_next    = BranchTaken ? target : redirect_pc;
                    state_next = FETCH;
                end
            end
            HOLD: begin
                if (BranchTaken) begin
                    pc_next    = target;
                    ifid_flush = 1'b1;
                    state_next = FETCH;
                end else if (!Stall) begin
                    // PC already advanced past the skid word when it was captured.
                    ifid_instr_d   = skid;
                    ifid_pcplus4_d = pc;
                    ifid_load      = 1'b1;
                    state_next     = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    if_id_register #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .instr_d  (ifid_instr_d),
        .pcplus4_d(ifid_pcplus4_d),
        .instr    (Instr),
        .pcplus4  (PCPlus4),
        .valid    (InstrValid)
    );

    assign OPCode = Instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scenario bench for instruction_fetch_stage: a bench-side instruction memory,
// an expected queue of {instr, pcplus4} and one task per scenario.
module tb_instruction_fetch_stage;
    import mips_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         Stall = 1'b0;
    logic         BranchTaken = 1'b0;
    logic [31:0]  BranchTarget = 32'h0;
    logic         ImemReq;
    logic [31:0]  ImemAddr;
    logic [31:0]  ImemRdata = 32'h0;
    logic         ImemAck = 1'b0;
    logic [31:0]  Instr;
    logic [5:0]   OPCode;
    logic [31:0]  PCPlus4;
    logic         InstrValid;
    fetch_state_e state_dbg;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp;
    logic [31:0] pc_model;
    logic [31:0] held_instr;
    logic [31:0] held_pc4;

    instruction_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemRdata   (ImemRdata),
        .ImemAck     (ImemAck),
        .Instr       (Instr),
        .OPCode      (OPCode),
        .PCPlus4     (PCPlus4),
        .InstrValid  (InstrValid),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h8C01_0004;
            32'h0000_0004: mem_word = 32'h0022_1820;
            default:       mem_word = (a * 32'h9E37_79B9) ^ 32'h1357_2468;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", ImemReq); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", InstrValid); end
        checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", Instr); end
        checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", PCPlus4); end
        checks++; if (state_dbg !== FETCH) begin errors++; $display("FAIL rst_state got %0d want %0d", state_dbg, FETCH); end
        cycle();
        reset = 1'b0;
        #1;
        checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL rel_req got %b want 1", ImemReq); end
        checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL rel_addr got %h want 0", ImemAddr); end
    endtask

    task automatic test_zero_wait();
        ImemAck = 1'b1;
        ImemRdata = mem_word(32'h0);
        exp_q.push_back({mem_word(32'h0), 32'h4});
        cycle();
        checks++; if (ImemAddr !== 32'h4) begin errors++; $display("FAIL zw_addr4 got %h want 4", ImemAddr); end
        exp = exp_q.pop_front();
        checks++; if (Instr !== exp[63:32]) begin errors++; $display("FAIL zw_instr0 got %h want %h", Instr, exp[63:32]); end
        checks++; if (PCPlus4 !== exp[31:0]) begin errors++; $display("FAIL zw_pc4_0 got %h want %h", PCPlus4, exp[31:0]); end
        checks++; if (OPCode !== 6'h23) begin errors++; $display("FAIL zw_op0 got %h want 23", OPCode); end
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL zw_valid0 got %b want 1", InstrValid); end
        ImemRdata = mem_word(32'h4);
        exp_q.push_back({mem_word(32'h4), 32'h8});
        cycle();
        ImemAck = 1'b0;
        checks++; if (ImemAddr !== 32'h8) begin errors++; $display("FAIL zw_addr8 got %h want 8", ImemAddr); end
        exp = exp_q.pop_front();
        checks++; if (Instr !== exp[63:32]) begin errors++; $display("FAIL zw_instr1 got %h want %h", Instr, exp[63:32]); end
        checks++; if (PCPlus4 !== exp[31:0]) begin errors++; $display("FAIL zw_pc4_1 got %h want %h", PCPlus4, exp[31:0]); end
        checks++; if (OPCode !== 6'h00) begin errors++; $display("FAIL zw_op1 got %h want 00", OPCode); end
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL zw_valid1 got %b want 1", InstrValid); end
    endtask

    task automatic test_latency();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin errors++; $display("FAIL lat_hold%0d got req %b addr %h want 1 0", i, ImemReq, ImemAddr); end
            checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL lat_valid%0d got %b want 0", i, InstrValid); end
            if (i == 2) begin
                ImemAck = 1'b1;
                ImemRdata = mem_word(32'h0);
                exp_q.push_back({mem_word(32'h0), 32'h4});
            end
            cycle();
        end
        ImemAck = 1'b0;
        checks++; if (ImemAddr !== 32'h4) begin errors++; $display("FAIL lat_addr got %h want 4", ImemAddr); end
        exp = exp_q.pop_front();
        checks++; if (Instr !== exp[63:32] || InstrValid !== 1'b1) begin errors++; $display("FAIL lat_instr got %h/%b want %h/1", Instr, InstrValid, exp[63:32]); end
    endtask

    task automatic test_stall_hold();
        ImemAck = 1'b1;
        ImemRdata = mem_word(32'h4);
        exp_q.push_back({mem_word(32'h4), 32'h8});
        cycle();
        exp = exp_q.pop_front();
        held_instr = exp[63:32];
        held_pc4 = exp[31:0];
        Stall = 1'b1;
        ImemRdata = mem_word(32'h8);
        exp_q.push_back({mem_word(32'h8), 32'hC});
        cycle();
        ImemAck = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (ImemReq !== 1'b0 || state_dbg !== HOLD) begin errors++; $display("FAIL hold_req%0d got %b/%0d want 0/%0d", i, ImemReq, state_dbg, HOLD); end
            checks++; if (Instr !== held_instr || PCPlus4 !== held_pc4) begin errors++; $display("FAIL hold_ifid%0d got %h/%h want %h/%h", i, Instr, PCPlus4, held_instr, held_pc4); end
            if (i == 0) cycle();
        end
        Stall = 1'b0;
        cycle();
        exp = exp_q.pop_front();
        checks++; if (Instr !== exp[63:32] || PCPlus4 !== exp[31:0]) begin errors++; $display("FAIL hold_rel got %h/%h want %h/%h", Instr, PCPlus4, exp[63:32], exp[31:0]); end
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'hC) begin errors++; $display("FAIL hold_next got %b/%h want 1/c", ImemReq, ImemAddr); end
    endtask

    task automatic test_branch_discard();
        ImemAck = 1'b1;
        ImemRdata = mem_word(32'hC);
        exp_q.push_back({mem_word(32'hC), 32'h10});
        cycle();
        ImemAck = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (Instr !== exp[63:32]) begin errors++; $display("FAIL br_pre got %h want %h", Instr, exp[63:32]); end
        BranchTaken = 1'b1;
        BranchTarget = 32'h40;
        cycle();
        checks++; if (state_dbg !== DISCARD || ImemAddr !== 32'h10 || ImemReq !== 1'b1) begin errors++; $display("FAIL br_disc got %0d/%h/%b want %0d/10/1", state_dbg, ImemAddr, ImemReq, DISCARD); end
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h0) begin errors++; $display("FAIL br_flush got %b/%h want 0/0", InstrValid, Instr); end
        BranchTarget = 32'h83;
        cycle();
        BranchTaken = 1'b0;
        checks++; if (ImemAddr !== 32'h10) begin errors++; $display("FAIL br_wait got %h want 10", ImemAddr); end
        ImemAck = 1'b1;
        ImemRdata = mem_word(32'h10);
        cycle();
        ImemAck = 1'b0;
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h0) begin errors++; $display("FAIL br_drop got %b/%h want 0/0", InstrValid, Instr); end
        checks++; if (ImemAddr !== 32'h80 || state_dbg !== FETCH) begin errors++; $display("FAIL br_target got %h/%0d want 80/%0d", ImemAddr, state_dbg, FETCH); end
    endtask

    task automatic test_branch_in_hold();
        ImemAck = 1'b1;
        ImemRdata = mem_word(32'h80);
        exp_q.push_back({mem_word(32'h80), 32'h84});
        cycle();
        exp = exp_q.pop_front();
        checks++; if (Instr !== exp[63:32] || PCPlus4 !== exp[31:0]) begin errors++; $display("FAIL bh_pre got %h/%h want %h/%h", Instr, PCPlus4, exp[63:32], exp[31:0]); end
        Stall = 1'b1;
        ImemRdata = mem_word(32'h84);
        cycle();
        ImemAck = 1'b0;
        checks++; if (state_dbg !== HOLD) begin errors++; $display("FAIL bh_hold got %0d want %0d", state_dbg, HOLD); end
        BranchTaken = 1'b1;
        BranchTarget = 32'h100;
        cycle();
        BranchTaken = 1'b0;
        Stall = 1'b0;
        checks++; if (Instr !== 32'h0 || InstrValid !== 1'b0) begin errors++; $display("FAIL bh_flush got %h/%b want 0/0", Instr, InstrValid); end
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin errors++; $display("FAIL bh_target got %b/%h want 1/100", ImemReq, ImemAddr); end
    endtask

    task automatic test_wrap();
        ImemAck = 1'b1;
        ImemRdata = mem_word(32'h100);
        BranchTaken = 1'b1;
        BranchTarget = 32'hFFFF_FFFC;
        cycle();
        BranchTaken = 1'b0;
        checks++; if (InstrValid !== 1'b0 || ImemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_ackbr got %b/%h want 0/fffffffc", InstrValid, ImemAddr); end
        ImemRdata = mem_word(32'hFFFF_FFFC);
        exp_q.push_back({mem_word(32'hFFFF_FFFC), 32'h0});
        cycle();
        ImemAck = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (Instr !== exp[63:32] || PCPlus4 !== exp[31:0]) begin errors++; $display("FAIL wr_ifid got %h/%h want %h/%h", Instr, PCPlus4, exp[63:32], exp[31:0]); end
        checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL wr_addr got %h want 0", ImemAddr); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int stl;
        pc_model = 32'h0;
        for (int k = 0; k < 16; k++) begin
            lat = $urandom_range(0, 2);
            stl = $urandom_range(0, 2);
            for (int j = 0; j < lat; j++) begin
                checks++; if (ImemReq !== 1'b1 || ImemAddr !== pc_model) begin errors++; $display("FAIL bb_wait%0d got %b/%h want 1/%h", k, ImemReq, ImemAddr, pc_model); end
                cycle();
            end
            ImemAck = 1'b1;
            ImemRdata = mem_word(pc_model);
            Stall = (stl != 0);
            exp_q.push_back({mem_word(pc_model), pc_model + 32'd4});
            cycle();
            ImemAck = 1'b0;
            pc_model = pc_model + 32'd4;
            if (stl != 0) begin
                checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL bb_hold%0d got %b want 0", k, ImemReq); end
                for (int j = 1; j < stl; j++) cycle();
                Stall = 1'b0;
                cycle();
            end
            exp = exp_q.pop_front();
            checks++; if (Instr !== exp[63:32] || PCPlus4 !== exp[31:0] || InstrValid !== 1'b1) begin errors++; $display("FAIL bb_ifid%0d got %h/%h/%b want %h/%h/1", k, Instr, PCPlus4, InstrValid, exp[63:32], exp[31:0]); end
            checks++; if (ImemAddr !== pc_model) begin errors++; $display("FAIL bb_addr%0d got %h want %h", k, ImemAddr, pc_model); end
        end
    endtask

    task automatic test_reset_mid();
        Stall = 1'b1;
        cycle();
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL rm_pre got %b want 1", InstrValid); end
        #2;
        reset = 1'b1;
        ImemAck = 1'b1;
        ImemRdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (Instr !== 32'h0 || PCPlus4 !== 32'h0 || InstrValid !== 1'b0) begin errors++; $display("FAIL rm_async got %h/%h/%b want 0/0/0", Instr, PCPlus4, InstrValid); end
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rm_req got %b want 0", ImemReq); end
        cycle();
        reset = 1'b0;
        ImemAck = 1'b0;
        Stall = 1'b0;
        #1;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0 || state_dbg !== FETCH) begin errors++; $display("FAIL rm_rel got %b/%h/%0d want 1/0/%0d", ImemReq, ImemAddr, state_dbg, FETCH); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rm_ackign got %b want 0", InstrValid); end
        ImemAck = 1'b1;
        ImemRdata = mem_word(32'h0);
        exp_q.push_back({mem_word(32'h0), 32'h4});
        cycle();
        ImemAck = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (Instr !== exp[63:32] || PCPlus4 !== exp[31:0]) begin errors++; $display("FAIL rm_first got %h/%h want %h/%h", Instr, PCPlus4, exp[63:32], exp[31:0]); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_empty got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_branch_discard();
        test_branch_in_hold();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
